// File: rtl/armaria_isa_pkg.sv
// Shared ISA definitions for the instruction sequencer: ID constants,
// instruction classes and sequencer state encoding.
package armaria_isa_pkg;

    localparam logic [6:0] ID_BUBBLE = 7'd0;
    localparam logic [6:0] ID_RESET  = 7'd100;
    localparam logic [6:0] ID_SWI    = 7'd72;
    localparam logic [6:0] ID_USR    = 7'd74;
    localparam logic [6:0] ID_HALT   = 7'd75;
    localparam logic [6:0] ID_INSW   = 7'd71;

    // Memory-class IDs: one contiguous range plus two isolated IDs.
    localparam logic [6:0] MEM_LO    = 7'd38;
    localparam logic [6:0] MEM_HI    = 7'd55;
    localparam logic [6:0] MEM_X0    = 7'd67;
    localparam logic [6:0] MEM_X1    = 7'd68;

    // Everything from here up to 127 is unassigned.
    localparam logic [6:0] ILLEGAL_LO = 7'd76;

    localparam int RESET_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        CLS_SIMPLE,
        CLS_MEM,
        CLS_IO,
        CLS_HALT,
        CLS_ILLEGAL
    } id_class_t;

    typedef enum logic [1:0] {
        RST_SEQ,
        FETCH,
        EXEC,
        HALTED
    } seq_state_t;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Decoder handshake and memory request/ack signals of the sequencer.
interface instruction_sequencer_if;
    logic       instr_valid;
    logic [6:0] instr_id;
    logic       instr_ready;
    logic       mem_req;
    logic       mem_ack;

    // Decoder / memory side.
    modport master (
        output instr_valid,
        output instr_id,
        output mem_ack,
        input  instr_ready,
        input  mem_req
    );

    // Sequencer side.
    modport slave (
        input  instr_valid,
        input  instr_id,
        input  mem_ack,
        output instr_ready,
        output mem_req
    );
endinterface

// File: rtl/id_classifier.sv
// Combinational classification of a 7-bit instruction ID.
module id_classifier
    import armaria_isa_pkg::*;
(
    input  logic [6:0] id,
    output id_class_t  cls
);

    // Illegal takes priority; remaining IDs fall through to SIMPLE.
    always_comb begin
        cls = CLS_SIMPLE;
        if (id == ID_BUBBLE || id >= ILLEGAL_LO) begin
            cls = CLS_ILLEGAL;
        end else if ((id >= MEM_LO && id <= MEM_HI) || id == MEM_X0 || id == MEM_X1) begin
            cls = CLS_MEM;
        end else if (id == ID_INSW) begin
            cls = CLS_IO;
        end else if (id == ID_HALT) begin
            cls = CLS_HALT;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: takes decoded IDs from the decoder, drives them to
// the control core for as long as each instruction executes, and tracks
// privilege mode, retire count and illegal-ID occurrences.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RST_SEQ | post-reset hold, ID=100 for RESET_CYCLES cycles
// FETCH   | ready for the next ID, ID=0 bubble
// EXEC    | captured ID driven; waits for mem_ack / io_enter when needed
// HALTED  | stopped after HALT retires, leaves on resume
module instruction_sequencer
    import armaria_isa_pkg::*;
#(
    parameter int RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int COUNT_W      = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    instruction_sequencer_if.slave bus,
    output logic [6:0]             ID,
    output logic                   MODE,
    input  logic                   io_enter,
    input  logic                   resume,
    output logic                   pc_advance,
    output logic                   halted,
    output logic                   illegal_instr,
    output logic [COUNT_W-1:0]     retired_count
);

    localparam int CNT_W = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_CYCLES - 1);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] rst_cnt, cnt_nxt;
    logic [6:0]       id_nxt;
    logic [6:0]       cur_id;
    id_class_t        cur_cls;
    id_class_t        cls_in;
    logic             accept;
    logic             done;

    id_classifier u_classifier (
        .id  (bus.instr_id),
        .cls (cls_in)
    );

    // ID is registered from the next state so it changes on the same edge
    // as the state, giving exactly one cycle from accept to ID.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= RST_SEQ;
            rst_cnt       <= CNT_LOAD;
            ID            <= ID_RESET;
            cur_id        <= ID_BUBBLE;
            cur_cls       <= CLS_SIMPLE;
            MODE          <= 1'b0;
            pc_advance    <= 1'b0;
            illegal_instr <= 1'b0;
            retired_count <= '0;
        end else begin
            state      <= state_nxt;
            rst_cnt    <= cnt_nxt;
            ID         <= id_nxt;
            pc_advance <= done;
            if (accept) begin
                cur_id  <= bus.instr_id;
                cur_cls <= cls_in;
                if (cls_in == CLS_ILLEGAL) begin
                    illegal_instr <= 1'b1;
                end
            end
            if (done) begin
                retired_count <= retired_count + COUNT_W'(1);
                if (cur_id == ID_SWI) begin
                    MODE <= 1'b1;
                end else if (cur_id == ID_USR) begin
                    MODE <= 1'b0;
                end
            end
        end
    end

    // Next-state, next-ID and completion decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = rst_cnt;
        id_nxt    = ID;
        accept    = 1'b0;
        done      = 1'b0;
        unique case (state)
            RST_SEQ: begin
                if (rst_cnt == '0) begin
                    state_nxt = FETCH;
                    id_nxt    = ID_BUBBLE;
                end else begin
                    cnt_nxt = rst_cnt - CNT_W'(1);
                end
            end
            FETCH: begin
                if (bus.instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                    id_nxt    = (cls_in == CLS_ILLEGAL) ? ID_BUBBLE : bus.instr_id;
                end
            end
            EXEC: begin
                case (cur_cls)
                    CLS_MEM: done = bus.mem_ack;
                    CLS_IO:  done = io_enter;
                    default: done = 1'b1;
                endcase
                if (done) begin
                    id_nxt    = ID_BUBBLE;
                    state_nxt = (cur_cls == CLS_HALT) ? HALTED : FETCH;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = RST_SEQ;
            end
        endcase
    end

    assign bus.instr_ready = (state == FETCH);
    assign bus.mem_req     = (state == EXEC) && (cur_cls == CLS_MEM);
    assign halted          = (state == HALTED);

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 4, sets the number of cycles ID=100 is driven after reset.
REQ-002 Parameter COUNT_W, default 32, sets the width of the retired-instruction counter.
REQ-003 Port clock, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 Port instr_valid, input, 1 bit: decoded instruction ID available from the decoder.
REQ-006 Port instr_id, input, 7 bits: decoded instruction ID, same encoding as the control core ID bus.
REQ-007 Port instr_ready, output, 1 bit: sequencer accepts instr_id this cycle.
REQ-008 Port ID, output, 7 bits: registered instruction ID driven to the control core.
REQ-009 Port MODE, output, 1 bit: privilege mode to the control core (0 = user, 1 = supervisor).
REQ-010 Port mem_req, output, 1 bit: memory transaction in progress.
REQ-011 Port mem_ack, input, 1 bit: memory transaction complete.
REQ-012 Port io_enter, input, 1 bit: single-cycle pulse from the switch-input confirm button.
REQ-013 Port resume, input, 1 bit: single-cycle pulse that leaves HALTED.
REQ-014 Port pc_advance, output, 1 bit: one-cycle pulse when an instruction retires.
REQ-015 Port halted, output, 1 bit: high while in HALTED.
REQ-016 Port illegal_instr, output, 1 bit: sticky flag, set when an illegal ID is accepted.
REQ-017 Port retired_count, output, COUNT_W bits: number of retired instructions.

Function
REQ-018 The FSM SHALL have exactly these states: RST_SEQ, FETCH, EXEC, HALTED.
REQ-019 RST_SEQ SHALL drive ID=100 and instr_ready=0 for RESET_CYCLES cycles, then go to FETCH.
REQ-020 FETCH SHALL drive instr_ready=1 and ID=0 (bubble).
REQ-021 On instr_valid&instr_ready in FETCH, the sequencer SHALL capture instr_id and go to EXEC.
REQ-022 Accept-to-ID latency SHALL be exactly 1 cycle.
REQ-023 ID SHALL hold the captured value for every cycle spent in EXEC.
REQ-024 Each captured ID SHALL be classified as follows: MEM = 38..55, 67, 68; IO = 71; HALT = 75; ILLEGAL = 0, 76..127; SIMPLE = all other values.
REQ-025 SIMPLE and ILLEGAL IDs SHALL complete in their first EXEC cycle.
REQ-026 A MEM ID SHALL complete in the EXEC cycle where mem_ack=1.
REQ-027 A MEM ID SHALL assert mem_req in every EXEC cycle up to and including the ack cycle; mem_req=0 in all other states.
REQ-028 An IO ID SHALL complete in the EXEC cycle where io_enter=1.
REQ-029 A HALT ID SHALL complete in its first EXEC cycle and then go to HALTED; all other IDs return to FETCH on completion.
REQ-030 On completion, pc_advance SHALL pulse for 1 cycle and retired_count SHALL increment, wrapping from all-ones to 0.
REQ-031 A simple instruction SHALL occupy 2 cycles; the next instr_ready=1 occurs 2 cycles after acceptance.
REQ-032 An ILLEGAL ID SHALL drive ID=0 instead of the captured value, set illegal_instr, and retire normally.
REQ-033 illegal_instr SHALL be cleared only by reset.
REQ-034 MODE SHALL be set to 1 when ID 72 (SWI) retires and cleared to 0 when ID 74 retires; it is unchanged otherwise.
REQ-035 HALTED SHALL drive ID=0, instr_ready=0 and halted=1; resume SHALL move it to FETCH on the next cycle.
REQ-036 resume outside HALTED, mem_ack outside a MEM EXEC, and io_enter outside an IO EXEC SHALL be ignored.
REQ-037 instr_valid SHALL be ignored while instr_ready=0.

Reset
REQ-038 Reset SHALL be sampled only on the rising edge of clock, when reset=0.
REQ-039 Reset values: state=RST_SEQ with its counter restarted, ID=100, MODE=0, mem_req=0, pc_advance=0, halted=0, illegal_instr=0, retired_count=0, instr_ready=0.
REQ-040 Reset asserted in any state, including mid-MEM or mid-IO EXEC, SHALL abort the instruction without retiring it and drop mem_req in the next cycle.

Structure
REQ-041 ID constants (RESET=100, SWI=72, ID 74, HALT=75, INSW=71, MEM ranges), the class enum, and the RESET_CYCLES default SHALL reside in the shared package armaria_isa_pkg.
REQ-042 ID classification SHALL be a combinational sub-module id_classifier (input: 7-bit ID; output: class).

Verification
REQ-043 Release reset with RESET_CYCLES=4 -> ID=100 for 4 cycles, then instr_ready=1 and ID=0.
REQ-044 Accept ID 4, then ID 12 back-to-back -> ID=4 for 1 cycle, pc_advance pulses, retired_count=2, instr_ready period is 2 cycles.
REQ-045 Accept ID 44 with mem_ack delayed 3 cycles -> ID=44 and mem_req=1 for 4 cycles, a single pc_advance, mem_req=0 afterwards.
REQ-046 Accept ID 72, then ID 74 -> MODE goes 0->1 after the SWI retires, then back to 0.
REQ-047 Accept ID 75, pulse resume 5 cycles later -> halted=1 for 5 cycles with ID=0, then FETCH; accepting ID 90 -> ID=0 and illegal_instr=1.
REQ-048 Assert reset during ID 71 IO wait -> no retire, state RST_SEQ, ID=100, retired_count=0.
